// File: rtl/rd_port_rr_arbiter.sv
// rd_port_rr_arbiter: round-robin sharing of one go/ds read engine between NREQ requesters
`timescale 1ns/1ps
module rd_port_rr_arbiter #(
   parameter int NREQ      = 4,
   parameter int TO_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [NREQ-1:0] done_o,
   output logic [NREQ-1:0] err_o,
   output logic            go_o,
   input  logic            ds_i,
   output logic            busy_o
);
   localparam int PW = $clog2(NREQ);
   localparam int WW = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
   localparam logic [WW-1:0] WD_LAST = (TO_CYCLES > 0) ? WW'(TO_CYCLES - 1) : '0;
   localparam logic [PW-1:0] PTR_MAX = PW'(NREQ - 1);
   typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WAIT, S_REL, S_ABORT} state_t;
   state_t          state_q;
   logic [PW-1:0]   owner_q;
   logic [PW-1:0]   rr_ptr_q;
   logic [WW-1:0]   wd_cnt_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] done_q;
   logic [NREQ-1:0] err_q;
   logic            go_q;
   logic            busy_q;
   logic [PW-1:0]   sel_d;
   logic            hit_d;
   logic [PW-1:0]   nxt_ptr_d;
   function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] a, int k);
      int s;
      s = int'(a) + k;
      return PW'((s >= NREQ) ? s - NREQ : s);
   endfunction
   function automatic logic [NREQ-1:0] onehot(logic [PW-1:0] i);
      return NREQ'(1) << i;
   endfunction
   // first requester at or above the round-robin pointer, wrapping past NREQ-1
   always_comb begin
      sel_d = rr_ptr_q;
      hit_d = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!hit_d && req_i[wrap_add(rr_ptr_q, k)]) begin
            hit_d = 1'b1;
            sel_d = wrap_add(rr_ptr_q, k);
         end
      end
      nxt_ptr_d = (owner_q == PTR_MAX) ? '0 : owner_q + 1'b1;
   end
   // transaction sequencer with registered grant/go/done/err/busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         wd_cnt_q <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         err_q    <= '0;
         go_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hit_d) begin
                  state_q  <= S_GRANT;
                  owner_q  <= sel_d;
                  gnt_q    <= onehot(sel_d);
                  go_q     <= 1'b1;
                  busy_q   <= 1'b1;
                  wd_cnt_q <= '0;
               end
            end
            S_GRANT: begin
               state_q  <= S_WAIT;
               go_q     <= 1'b0;
               wd_cnt_q <= '0;
            end
            S_WAIT: begin
               if (ds_i) begin
                  state_q  <= S_REL;
                  gnt_q    <= '0;
                  done_q   <= onehot(owner_q);
                  rr_ptr_q <= nxt_ptr_d;
               end else if (TO_CYCLES != 0 && wd_cnt_q == WD_LAST) begin
                  state_q  <= S_ABORT;
                  gnt_q    <= '0;
                  err_q    <= onehot(owner_q);
                  rr_ptr_q <= nxt_ptr_d;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 1'b1;
               end
            end
            S_REL, S_ABORT: begin
               state_q <= S_IDLE;
               done_q  <= '0;
               err_q   <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= '0;
               done_q  <= '0;
               err_q   <= '0;
               go_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
   assign gnt_o  = gnt_q;
   assign done_o = done_q;
   assign err_o  = err_q;
   assign go_o   = go_q;
   assign busy_o = busy_q;
endmodule

// File: tb/tb_rd_port_rr_arbiter.sv
// tb_rd_port_rr_arbiter: directed checks of grant order, latency, watchdog and reset
`timescale 1ns/1ps
module tb_rd_port_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic ds = 1'b0;
  logic [3:0] gnt, done, err;
  logic go, busy;
  int tests = 0;
  int fails = 0;
  rd_port_rr_arbiter #(.NREQ(4), .TO_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .done_o(done),
    .err_o(err), .go_o(go), .ds_i(ds), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (gnt == 4'b0000 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_gnt_seen"}, n < 20, 1);
  endtask
  task automatic txn(input logic [3:0] exp_g, input int dly, input string tag);
    wait_gnt(tag);
    chk({tag, "_gnt"}, gnt, exp_g);
    chk({tag, "_go"}, go, 1);
    repeat (dly) step();
    ds = 1'b1;
    step();
    ds = 1'b0;
    chk({tag, "_done"}, done, exp_g);
    chk({tag, "_rel_gnt"}, gnt, 0);
    step();
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_done"}, done, 0);
  endtask
  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_go", go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ptr", dut.rr_ptr_q, 0);
    req = 4'b0100;
    step();
    chk("s_gnt", gnt, 4'b0100);
    chk("s_go", go, 1);
    chk("s_busy", busy, 1);
    step();
    chk("s_wait_go", go, 0);
    chk("s_wait_gnt", gnt, 4'b0100);
    step();
    step();
    ds = 1'b1;
    step();
    ds = 1'b0;
    chk("s_done", done, 4'b0100);
    chk("s_done_gnt", gnt, 0);
    chk("s_done_busy", busy, 1);
    step();
    req = 4'b0000;
    chk("s_done_off", done, 0);
    chk("s_busy_off", busy, 0);
    chk("s_ptr", dut.rr_ptr_q, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("f_ptr0", dut.rr_ptr_q, 0);
    req = 4'b1111;
    txn(4'b0001, 2, "f0");
    txn(4'b0010, 1, "f1");
    txn(4'b0100, 3, "f2");
    txn(4'b1000, 1, "f3");
    txn(4'b0001, 2, "f4");
    chk("f_ptr1", dut.rr_ptr_q, 1);
    req = 4'b1001;
    txn(4'b1000, 1, "p3");
    txn(4'b0001, 1, "p0");
    req = 4'b0000;
    chk("p_ptr", dut.rr_ptr_q, 1);
    req = 4'b0010;
    wait_gnt("wd");
    chk("wd_gnt", gnt, 4'b0010);
    req = 4'b0000;
    repeat (16) step();
    chk("wd_last_gnt", gnt, 4'b0010);
    chk("wd_last_err", err, 0);
    step();
    chk("wd_err", err, 4'b0010);
    chk("wd_nodone", done, 0);
    chk("wd_gnt_off", gnt, 0);
    step();
    chk("wd_err_off", err, 0);
    chk("wd_busy_off", busy, 0);
    chk("wd_ptr", dut.rr_ptr_q, 2);
    req = 4'b0100;
    wait_gnt("wl");
    chk("wl_gnt", gnt, 4'b0100);
    req = 4'b0000;
    repeat (16) step();
    ds = 1'b1;
    step();
    ds = 1'b0;
    chk("wl_done", done, 4'b0100);
    chk("wl_noerr", err, 0);
    step();
    chk("wl_ptr", dut.rr_ptr_q, 3);
    req = 4'b1000;
    wait_gnt("dr");
    chk("dr_gnt", gnt, 4'b1000);
    req = 4'b0000;
    step();
    step();
    ds = 1'b1;
    step();
    ds = 1'b0;
    chk("dr_done", done, 4'b1000);
    step();
    chk("dr_idle_gnt", gnt, 0);
    chk("dr_ptr", dut.rr_ptr_q, 0);
    req = 4'b0010;
    wait_gnt("ar");
    chk("ar_gnt", gnt, 4'b0010);
    req = 4'b0000;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_off", gnt, 0);
    chk("ar_go_off", go, 0);
    chk("ar_busy_off", busy, 0);
    chk("ar_ptr", dut.rr_ptr_q, 0);
    ds = 1'b1;
    step();
    ds = 1'b0;
    rst_n = 1'b1;
    step();
    chk("ar_nodone", done, 0);
    chk("ar_noerr", err, 0);
    chk("ar_idle_gnt", gnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
